// File: rtl/regfile_mp_pkg.sv
// Shared defaults, port-count limits and packed-bus slice macros for the multi-port register file.
`ifndef REGFILE_MP_PKG_MACROS
`define REGFILE_MP_PKG_MACROS
`define RF_SL(k, w) (k)*(w) +: (w)
`endif

package regfile_mp_pkg;
  localparam int RF_DATA_WIDTH_DEF = 32;
  localparam int RF_NUM_REGS_DEF   = 32;
  localparam int RF_MAX_RD_PORTS   = 4;
  localparam int RF_MAX_WR_PORTS   = 3;
endpackage

// File: rtl/regfile_wr_resolve.sv
// Per-register write select and winning data for all write ports; highest port index wins a collision.
// Purely combinational; register 0 is never selected, so its pending clear is also tied off.
module regfile_wr_resolve
  import regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH   = RF_DATA_WIDTH_DEF,
  parameter int NUM_REGS     = RF_NUM_REGS_DEF,
  parameter int NUM_WR_PORTS = 2,
  parameter int AW           = $clog2(NUM_REGS)
) (
  input  logic [NUM_WR_PORTS-1:0]            i_wr_en,
  input  logic [NUM_WR_PORTS*AW-1:0]         i_wr_addr,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] i_wr_data,
  output logic [NUM_REGS-1:0]                o_sel,
  output logic [NUM_REGS*DATA_WIDTH-1:0]     o_data,
  output logic [NUM_REGS-1:0]                o_clr_pend
);

  always_comb begin
    o_sel  = '0;
    o_data = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      // Ascending port order: a later (higher) port overwrites an earlier match.
      for (int k = 0; k < NUM_WR_PORTS; k++) begin
        if (i_wr_en[k] && (i_wr_addr[`RF_SL(k, AW)] == AW'(r))) begin
          o_sel[r]                     = 1'b1;
          o_data[`RF_SL(r, DATA_WIDTH)] = i_wr_data[`RF_SL(k, DATA_WIDTH)];
        end
      end
    end
  end

  assign o_clr_pend = o_sel;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register pending scoreboard; reads are zero-latency, writes land next cycle.
// Define RF_BYPASS_EN to forward same-cycle write data (and pending state) to matching reads.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH   = RF_DATA_WIDTH_DEF,
  parameter int NUM_REGS     = RF_NUM_REGS_DEF,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 2,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [NUM_WR_PORTS-1:0]            i_wr_en,
  input  logic [NUM_WR_PORTS*AW-1:0]         i_wr_addr,
  input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] i_wr_data,
  input  logic [NUM_RD_PORTS*AW-1:0]         i_rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] o_rd_data,
  output logic [NUM_RD_PORTS-1:0]            o_rd_pending,
  input  logic                               i_issue_en,
  input  logic [AW-1:0]                      i_issue_addr,
  input  logic                               i_flush,
  output logic [AW:0]                        o_pending_cnt
);

  logic [DATA_WIDTH-1:0]          r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]            r_pend;
  logic [AW:0]                    r_pend_cnt;

  logic [NUM_REGS-1:0]            w_sel;
  logic [NUM_REGS*DATA_WIDTH-1:0] w_data;
  logic [NUM_REGS-1:0]            w_clr_pend;
  logic [NUM_REGS-1:0]            w_pend_nxt;
  logic [AW:0]                    w_cnt_nxt;

  regfile_wr_resolve #(
    .DATA_WIDTH   (DATA_WIDTH),
    .NUM_REGS     (NUM_REGS),
    .NUM_WR_PORTS (NUM_WR_PORTS),
    .AW           (AW)
  ) u_wr_resolve (
    .i_wr_en    (i_wr_en),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .o_sel      (w_sel),
    .o_data     (w_data),
    .o_clr_pend (w_clr_pend)
  );

  // Issue is applied last so a new producer survives both a flush and a retiring write.
  always_comb begin
    w_pend_nxt = i_flush ? '0 : (r_pend & ~w_clr_pend);
    if (i_issue_en) begin
      w_pend_nxt[i_issue_addr] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_pend_nxt[r]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
      r_pend     <= '0;
      r_pend_cnt <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_sel[r]) begin
          r_regs[r] <= w_data[`RF_SL(r, DATA_WIDTH)];
        end
      end
      r_pend     <= w_pend_nxt;
      r_pend_cnt <= w_cnt_nxt;
    end
  end

  assign o_pending_cnt = r_pend_cnt;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [AW-1:0] w_ra;
    assign w_ra = i_rd_addr[`RF_SL(p, AW)];
`ifdef RF_BYPASS_EN
    // w_sel[0] is never set, so x0 stays zero and non-pending through the bypass too.
    assign o_rd_data[`RF_SL(p, DATA_WIDTH)] =
      (w_ra == '0) ? '0 :
      w_sel[w_ra]  ? w_data[`RF_SL(w_ra, DATA_WIDTH)] : r_regs[w_ra];
    assign o_rd_pending[p] =
      (w_ra == '0) ? 1'b0 :
      w_sel[w_ra]  ? (i_issue_en && (i_issue_addr == w_ra)) : r_pend[w_ra];
`else
    assign o_rd_data[`RF_SL(p, DATA_WIDTH)] = (w_ra == '0) ? '0 : r_regs[w_ra];
    assign o_rd_pending[p] = (w_ra == '0) ? 1'b0 : r_pend[w_ra];
`endif
  end

endmodule
